// File: rtl/arf_err_sched.sv
// Run sequencer and error-statistics engine for a pair of ARF datapaths.
// Each vector is launched into both paths; their outputs are compared after a fixed settle time.
module arf_err_sched #(
  parameter int DATA_W     = 32,
  parameter int ER_THRESH  = 16,
  parameter int DP_LATENCY = 4,
  parameter int CNT_W      = 32,
  parameter int ACC_W      = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_vec,
  input  logic                 vec_valid,
  output logic                 vec_ready,
  input  logic [10*DATA_W-1:0] vec_data,
  output logic [10*DATA_W-1:0] dp_in,
  output logic                 dp_launch,
  input  logic [DATA_W-1:0]    out_27_var,
  input  logic [DATA_W-1:0]    out_27_acc,
  input  logic [DATA_W-1:0]    out_28_var,
  input  logic [DATA_W-1:0]    out_28_acc,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     vec_cnt,
  output logic [4*CNT_W-1:0]   err_cnt,
  output logic [2*ACC_W-1:0]   err_sum,
  output logic [2*ACC_W-1:0]   abs_sum
);

  localparam int LAT_W = (DP_LATENCY < 2) ? 1 : $clog2(DP_LATENCY + 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_ACCUM, S_DONE} state_t;

  state_t                   state;
  logic [LAT_W-1:0]         lat_cnt;
  logic [CNT_W-1:0]         num_lat;
  logic [CNT_W-1:0]         er0_27, er1_27, er0_28, er1_28;
  logic signed [DATA_W-1:0] s27v, s27a, s28v, s28a;
  logic signed [ACC_W-1:0]  sum_27, sum_28, abs_27, abs_28;
  logic signed [ACC_W-1:0]  e27, e28, m27, m28;
  logic                     ne27, ne28, hi27, hi28;
  logic [CNT_W-1:0]         vec_next;

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [DATA_W-1:0] x);
    return {{(ACC_W-DATA_W){x[DATA_W-1]}}, x};
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != '1)) return v + CNT_W'(1);
    return v;
  endfunction

  always_comb begin
    e27  = sext(s27v) - sext(s27a);
    e28  = sext(s28v) - sext(s28a);
    m27  = (s27a > 0) ? sext(s27a) : -sext(s27a);
    m28  = (s28a > 0) ? sext(s28a) : -sext(s28a);
    ne27 = (e27 != '0);
    ne28 = (e28 != '0);
    hi27 = (s27v[DATA_W-1:ER_THRESH] != s27a[DATA_W-1:ER_THRESH]);
    hi28 = (s28v[DATA_W-1:ER_THRESH] != s28a[DATA_W-1:ER_THRESH]);
  end

  assign vec_next = sat_inc(vec_cnt, 1'b1);
  assign err_cnt  = {er1_28, er0_28, er1_27, er0_27};
  assign err_sum  = {sum_28, sum_27};
  assign abs_sum  = {abs_28, abs_27};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      lat_cnt   <= '0;
      num_lat   <= '0;
      vec_ready <= 1'b0;
      dp_in     <= '0;
      dp_launch <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      vec_cnt   <= '0;
      er0_27    <= '0;
      er1_27    <= '0;
      er0_28    <= '0;
      er1_28    <= '0;
      sum_27    <= '0;
      sum_28    <= '0;
      abs_27    <= '0;
      abs_28    <= '0;
      s27v      <= '0;
      s27a      <= '0;
      s28v      <= '0;
      s28a      <= '0;
    end else begin
      dp_launch <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            num_lat <= num_vec;
            vec_cnt <= '0;
            er0_27  <= '0;
            er1_27  <= '0;
            er0_28  <= '0;
            er1_28  <= '0;
            sum_27  <= '0;
            sum_28  <= '0;
            abs_27  <= '0;
            abs_28  <= '0;
            if (num_vec == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state     <= S_FETCH;
              vec_ready <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (vec_valid) begin
            dp_in     <= vec_data;
            dp_launch <= 1'b1;
            vec_ready <= 1'b0;
            lat_cnt   <= LAT_W'(DP_LATENCY);
            state     <= S_WAIT;
          end
        end
        // The counter spends one extra cycle at zero so sampling lands DP_LATENCY cycles after the launch cycle.
        S_WAIT: begin
          if (lat_cnt == '0) begin
            s27v  <= out_27_var;
            s27a  <= out_27_acc;
            s28v  <= out_28_var;
            s28a  <= out_28_acc;
            state <= S_ACCUM;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        S_ACCUM: begin
          er0_27  <= sat_inc(er0_27, ne27);
          er1_27  <= sat_inc(er1_27, hi27);
          er0_28  <= sat_inc(er0_28, ne28);
          er1_28  <= sat_inc(er1_28, hi28);
          sum_27  <= sum_27 + e27;
          sum_28  <= sum_28 + e28;
          abs_27  <= abs_27 + m27;
          abs_28  <= abs_28 + m28;
          vec_cnt <= vec_next;
          if (vec_next == num_lat) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state     <= S_FETCH;
            vec_ready <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          vec_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arf_err_sched.sv
// Bench for arf_err_sched: a delayed fake datapath pair, a random valid/ready source,
// and a reference model that recomputes the run statistics from the vectors sent.
module tb_arf_err_sched;

  localparam int DW = 32;
  localparam int ET = 16;
  localparam int L  = 4;
  localparam int CW = 32;
  localparam int AW = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [CW-1:0]   num_vec;
  logic            vec_valid;
  logic            vec_ready;
  logic [10*DW-1:0] vec_data;
  logic [10*DW-1:0] dp_in;
  logic            dp_launch;
  logic [DW-1:0]   out_27_var, out_27_acc, out_28_var, out_28_acc;
  logic            busy;
  logic            done;
  logic [CW-1:0]   vec_cnt;
  logic [4*CW-1:0] err_cnt;
  logic [2*AW-1:0] err_sum;
  logic [2*AW-1:0] abs_sum;

  int cmpCount = 0;
  int errCount = 0;
  logic [10*DW-1:0] vecQ[$];

  arf_err_sched #(
    .DATA_W(DW), .ER_THRESH(ET), .DP_LATENCY(L), .CNT_W(CW), .ACC_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data),
    .dp_in(dp_in), .dp_launch(dp_launch),
    .out_27_var(out_27_var), .out_27_acc(out_27_acc),
    .out_28_var(out_28_var), .out_28_acc(out_28_acc),
    .busy(busy), .done(done), .vec_cnt(vec_cnt),
    .err_cnt(err_cnt), .err_sum(err_sum), .abs_sum(abs_sum)
  );

  always #5 clk = ~clk;

  // Fake datapaths: words 0..3 of the launched vector appear only in the one cycle ending at the sampling edge.
  initial begin
    int k;
    logic [10*DW-1:0] held;
    k = 1000;
    held = '0;
    out_27_var = '0;
    out_27_acc = '0;
    out_28_var = '0;
    out_28_acc = '0;
    forever begin
      @(negedge clk);
      if (dp_launch) begin
        k = 0;
        held = dp_in;
      end else if (k < 1000) begin
        k++;
      end
      if (k == L) begin
        out_27_var = held[0*DW +: DW];
        out_27_acc = held[1*DW +: DW];
        out_28_var = held[2*DW +: DW];
        out_28_acc = held[3*DW +: DW];
      end else begin
        out_27_var = $urandom;
        out_27_acc = $urandom;
        out_28_var = $urandom;
        out_28_acc = $urandom;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [10*DW-1:0] observed,
                             input logic [10*DW-1:0] expected);
    cmpCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [10*DW-1:0] makeVec(input logic [DW-1:0] v27, input logic [DW-1:0] a27,
                                               input logic [DW-1:0] v28, input logic [DW-1:0] a28);
    logic [10*DW-1:0] v;
    for (int i = 0; i < 10; i++) v[i*DW +: DW] = $urandom;
    v[0*DW +: DW] = v27;
    v[1*DW +: DW] = a27;
    v[2*DW +: DW] = v28;
    v[3*DW +: DW] = a28;
    return v;
  endfunction

  // Pairs that are equal, slightly apart, or unrelated, with the most negative value mixed in.
  task automatic randPair(output logic [DW-1:0] v, output logic [DW-1:0] a);
    a = ($urandom_range(7) == 0) ? 32'h8000_0000 : $urandom;
    case ($urandom_range(2))
      0:       v = a;
      1:       v = a + $urandom_range(40) - 20;
      default: v = $urandom;
    endcase
  endtask

  task automatic pushRandom(input int n);
    logic [DW-1:0] v27, a27, v28, a28;
    for (int i = 0; i < n; i++) begin
      randPair(v27, a27);
      randPair(v28, a28);
      vecQ.push_back(makeVec(v27, a27, v28, a28));
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_ready"}, vec_ready, 0);
    checkOutput({tag, "_launch"}, dp_launch, 0);
    checkOutput({tag, "_dp_in"}, dp_in, 0);
    checkOutput({tag, "_vec_cnt"}, vec_cnt, 0);
    checkOutput({tag, "_err_cnt"}, err_cnt, 0);
    checkOutput({tag, "_err_sum"}, err_sum, 0);
    checkOutput({tag, "_abs_sum"}, abs_sum, 0);
  endtask

  // One run of n vectors from vecQ: drives the source, checks launches and timing, then the statistics.
  task automatic applyStimulus(input int n, input int gapPct, input int stall);
    logic [CW-1:0]    x0[2], x1[2];
    logic [AW-1:0]    es[2], ab[2];
    logic [10*DW-1:0] prevDp;
    logic [DW-1:0]    vv, aa;
    longint           e;
    int               idx, cycles, doneAt, stallLeft;
    bit               hsPend, doneSeen;

    for (int c = 0; c < 2; c++) begin
      x0[c] = '0; x1[c] = '0; es[c] = '0; ab[c] = '0;
    end
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < 2; c++) begin
        vv = vecQ[i][(2*c)*DW +: DW];
        aa = vecQ[i][(2*c+1)*DW +: DW];
        e = longint'($signed(vv)) - longint'($signed(aa));
        es[c] = es[c] + e;
        if (e != 0) x0[c]++;
        if ((vv >> ET) != (aa >> ET)) x1[c]++;
        ab[c] = ab[c] + (($signed(aa) < 0) ? -longint'($signed(aa)) : longint'($signed(aa)));
      end
    end

    @(negedge clk);
    num_vec = n;
    start = 1'b1;
    vec_valid = 1'b0;
    idx = 0; cycles = 0; doneAt = 0; hsPend = 0; doneSeen = 0;
    stallLeft = stall;
    prevDp = dp_in;
    while (!doneSeen && cycles < 3000) begin
      @(negedge clk);
      cycles++;
      start = 1'b0;
      checkOutput("busy_run", busy, 1);
      if (hsPend) begin
        checkOutput("launch", dp_launch, 1);
        checkOutput("dp_in_load", dp_in, vecQ[idx]);
        idx++;
      end else begin
        checkOutput("no_launch", dp_launch, 0);
        checkOutput("dp_in_hold", dp_in, prevDp);
      end
      prevDp = dp_in;
      if (done) begin
        doneSeen = 1;
        doneAt = cycles;
      end
      if (idx < n && vec_ready && stallLeft > 0) begin
        vec_valid = 1'b0;
        stallLeft--;
      end else begin
        vec_valid = (idx < n) && ($urandom_range(99) >= gapPct);
      end
      vec_data = (idx < n) ? vecQ[idx] : makeVec($urandom, $urandom, $urandom, $urandom);
      hsPend = vec_valid && vec_ready;
    end
    vec_valid = 1'b0;
    checkOutput("done_seen", doneSeen, 1);
    checkOutput("vectors_sent", idx, n);
    if (gapPct == 0) checkOutput("run_cycles", doneAt, n * (L + 3) + 1 + stall);

    @(negedge clk);
    checkOutput("idle_busy", busy, 0);
    checkOutput("done_pulse", done, 0);
    checkOutput("vec_cnt", vec_cnt, n);
    checkOutput("err_cnt", err_cnt, {x1[1], x0[1], x1[0], x0[0]});
    checkOutput("err_sum", err_sum, {es[1], es[0]});
    checkOutput("abs_sum", abs_sum, {ab[1], ab[0]});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit found;
    rst_n = 1'b1;
    start = 1'b0;
    vec_valid = 1'b0;
    num_vec = '0;
    vec_data = '0;
    #2 rst_n = 1'b0;
    #1 checkReset("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] three identical vectors, no error");
    vecQ.delete();
    repeat (3) vecQ.push_back(makeVec(100, 100, 100, 100));
    applyStimulus(3, 0, 0);

    $display("[TB] low-bit difference then high-field difference on out_27");
    vecQ.delete();
    vecQ.push_back(makeVec(32'h0001_0005, 32'h0001_0000, 0, 0));
    vecQ.push_back(makeVec(32'h0002_0000, 32'h0001_0000, 0, 0));
    applyStimulus(2, 0, 0);

    $display("[TB] negative and most-negative accurate values on out_28");
    vecQ.delete();
    vecQ.push_back(makeVec(0, 0, 5, -7));
    vecQ.push_back(makeVec(0, 0, 32'h7FFF_FFFF, 32'h8000_0000));
    applyStimulus(2, 0, 0);

    $display("[TB] source stalls five cycles in fetch");
    vecQ.delete();
    pushRandom(3);
    applyStimulus(3, 0, 5);

    $display("[TB] reset during wait of vector 2");
    vecQ.delete();
    pushRandom(3);
    @(negedge clk);
    num_vec = 3;
    start = 1'b1;
    vec_valid = 1'b1;
    vec_data = vecQ[0];
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (vec_cnt == 1 && dp_launch) found = 1;
    end
    checkOutput("wait_reached", found, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1 checkReset("mid_run");
    vec_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vecQ.delete();
    applyStimulus(0, 0, 0);

    $display("[TB] random runs");
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(8, 1);
      vecQ.delete();
      pushRandom(n);
      applyStimulus(n, (r % 2 == 0) ? 0 : 40, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
